// File: rtl/cv32e40x_alu_b_clmul_seq.sv
// Iterative carry-less multiplier (CLMUL/CLMULH/CLMULR), STEP multiplier bits per cycle.
// Optional early termination on exhausted multiplier: define CV32E40X_CLMUL_EARLY_TERM_EN.
module cv32e40x_alu_b_clmul_seq #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned STEP = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] op_a_i,
   input  logic [XLEN-1:0] op_b_i,
   input  logic            kill_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned NSTEPS = XLEN / STEP;
   localparam int unsigned CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   state_e            r_state;
   state_e            w_state_nxt;
   logic [2*XLEN-1:0] r_acc;
   logic [2*XLEN-1:0] r_a_sh;
   logic [XLEN-1:0]   r_b_sh;
   logic [1:0]        r_op;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_result;

   logic [2*XLEN-1:0] w_acc_nxt;
   logic [XLEN-1:0]   w_b_rem;
   logic [XLEN-1:0]   w_res;
   logic              w_accept;
   logic              w_last;

   // Operands are kept pre-shifted so each step only looks at the low STEP bits of b.
   always_comb begin
      w_acc_nxt = r_acc;
      for (int unsigned j = 0; j < STEP; j++) begin
         if (r_b_sh[j]) w_acc_nxt = w_acc_nxt ^ (r_a_sh << j);
      end
      w_b_rem = r_b_sh >> STEP;
`ifdef CV32E40X_CLMUL_EARLY_TERM_EN
      w_last = (r_cnt == CW'(NSTEPS - 1)) || (w_b_rem == '0);
`else
      w_last = (r_cnt == CW'(NSTEPS - 1));
`endif
      case (r_op)
         2'b01:   w_res = w_acc_nxt[2*XLEN-1:XLEN];
         2'b10:   w_res = w_acc_nxt[2*XLEN-2:XLEN-1];
         default: w_res = w_acc_nxt[XLEN-1:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Kill wins over both the output handshake and a same-cycle accept.
   always_comb begin
      w_state_nxt = r_state;
      ready_o     = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready_o = 1'b1;
            if (valid_i && !kill_i) begin
               w_accept    = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (kill_i)      w_state_nxt = S_IDLE;
            else if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            ready_o = ready_i;
            if (kill_i) begin
               w_state_nxt = S_IDLE;
            end else if (ready_i) begin
               if (valid_i) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_BUSY;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc    <= '0;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_op     <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_acc    <= '0;
         r_a_sh   <= {{XLEN{1'b0}}, op_a_i};
         r_b_sh   <= op_b_i;
         r_op     <= op_i;
         r_cnt    <= '0;
      end else if (r_state == S_BUSY && !kill_i) begin
         r_acc    <= w_acc_nxt;
         r_a_sh   <= r_a_sh << STEP;
         r_b_sh   <= w_b_rem;
         r_cnt    <= r_cnt + CW'(1);
         if (w_last) r_result <= w_res;
      end
   end

   assign valid_o  = (r_state == S_DONE);
   assign result_o = r_result;

endmodule
